seg7_capture: RTL and testbench
===============================

# seg7_capture

Loopback monitor on the seven-segment side of the tile: it samples the 7-bit segment bus driven onto `uo_out[6:0]`, filters glitches and mux transitions with a stability counter, and decodes each newly settled pattern back to a hex nibble. Decoded events are queued in a small first-word-fallthrough (FWFT) FIFO and drained over a valid/ready port. The block lets on-chip self-test and bench logic read back what the display logic actually shows, instead of comparing raw segment bits.

## Interface
- `STABLE_CYCLES`, default 4: consecutive identical samples required before a pattern is accepted. Legal range is 2..15.
- `DEPTH`, default 4: FIFO entries. Must be a power of two, at least 2.
- `clk` in, 1: the only clock. All state changes on its rising edge.
- `rst_n` in, 1: asynchronous, active-low reset.
- `ena` in, 1: sampling enable. When low, the filter freezes; the FIFO still drains.
- `seg_in` in, 7: segment bus. Bit 0 = a … bit 6 = g, active high.
- `out_valid` out, 1: FIFO not empty.
- `out_ready` in, 1: consumer accepts the head entry.
- `out_digit` out, 4: decoded nibble at the FIFO head.
- `out_invalid` out, 1: the head pattern is not in the decode table.
- `overflow` out, 1: sticky flag. Set when an accepted event is dropped because the FIFO is full.

## Operation
- Decode table (hex pattern → digit):
  - 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7
  - 7F→8, 6F→9, 77→A, 7C→b, 39→C, 5E→d, 79→E, 71→F
  - Any other pattern, including 00 (blank): `out_invalid`=1, `out_digit`=0.
- Filter state:
  - `cand` (7 bits): candidate pattern.
  - `cnt`: width clog2(STABLE_CYCLES+1), saturating.
  - `last` (7 bits): last accepted pattern.
- Each edge with `ena`=1:
  - If `seg_in` != `cand`: `cand`←`seg_in`, `cnt`←1.
  - Else if `cnt` < STABLE_CYCLES: `cnt`←`cnt`+1.
  - Else: hold.
- Accept: on the edge where `cnt` moves from STABLE_CYCLES−1 to STABLE_CYCLES, and `cand` != `last`:
  - `last`←`cand`.
  - A push of {invalid, digit} decoded from `cand` is requested.
- A pattern equal to `last` is never re-reported. Holding a pattern indefinitely produces exactly one event.
- `ena`=0: `cand`, `cnt` and `last` hold. No accept occurs.
- FIFO is FWFT:
  - `out_valid` = not empty; `out_digit` / `out_invalid` show the head entry.
  - Pop occurs when `out_valid` && `out_ready`.
  - Outputs are don't-care while `out_valid`=0, but must not be X after reset (0 required).
- Push and pop on the same edge:
  - Both take effect; occupancy is unchanged.
  - This holds when full: the pop frees a slot, so the push is accepted and `overflow` is not set.
  - When empty there is nothing to pop; the push is accepted.
- Push when full with no pop: the event is dropped and `overflow`←1. `last` is still updated.
- `overflow` clears only on reset.
- Pointers are log2(DEPTH)+1 bits (wrap bit distinguishes full from empty) and wrap modulo 2·DEPTH.

## Timing
- Reset values (asynchronous, immediate):
  - `out_valid`=0, `out_digit`=0, `out_invalid`=0, `overflow`=0.
  - `cand`=00, `cnt`=0, `last`=00, pointers=0.
- The reset value of `last`=00 means a blank display after reset produces no event.
- Latency: `seg_in` changes to a new pattern P before edge k and stays stable.
  - `cnt`=1 after edge k; it reaches STABLE_CYCLES at edge k+STABLE_CYCLES−1.
  - If the FIFO was empty, `out_valid`=1 with P's decode right after that edge. Default: 3 edges after first sample.
- A glitch shorter than STABLE_CYCLES samples is never reported. Counting restarts from 1 at the new value.
- Pop to next-head visibility: 0 cycles. The next entry is presented right after the popping edge.
- Reset asserted mid-operation: all queued events are lost and all outputs return to reset values at once. After deassertion, the first edge is an ordinary sampling edge.

## Test plan
- Reset with `seg_in`=00 held, `ena`=1 for 20 cycles → `out_valid` stays 0, `overflow`=0.
- `seg_in`=5B held for 10 cycles, `out_ready`=0 → `out_valid` rises after the 4th sampling edge with `out_digit`=2, `out_invalid`=0. Exactly one entry is queued.
- `seg_in` alternates 06/7F every 2 cycles for 12 cycles, then settles on 7F → only 7F is reported (digit 8). No event for 06.
- `out_ready`=0; settle 3F, 06, 5B, 4F, 66 (6 cycles each) → 4 entries read back in order as 0, 1, 2, 3. `overflow`=1 and 66 is lost. With `out_ready` held 1, digits 0..3 drain one per cycle.
- FIFO full; on the accept edge of 7C, `out_ready`=1 → no overflow, and the FIFO still holds 4 entries with b at the tail. Separately, pattern 55 → `out_invalid`=1, `out_digit`=0.
- `rst_n` pulsed low mid-stream with 2 entries queued → outputs 0 immediately. Re-settling the same pattern afterwards is reported again.

Source files
------------

// File: rtl/seg7_capture_if.sv
// Drain port of seg7_capture: FWFT head entry presented with a valid/ready handshake.
interface seg7_capture_if;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_digit;
    logic       out_invalid;

    modport master (output out_valid, output out_digit, output out_invalid, input out_ready);
    modport slave  (input out_valid, input out_digit, input out_invalid, output out_ready);
endinterface

// File: rtl/seg7_capture.sv
// Seven-segment loopback monitor: stability filter, hex decode of each newly
// settled pattern, and a small FWFT event FIFO drained over a valid/ready port.
module seg7_capture #(
    parameter int STABLE_CYCLES = 4,
    parameter int DEPTH         = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic [6:0]            seg_in,
    output logic                  overflow,
    seg7_capture_if.master        bus
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int AW = $clog2(DEPTH);

    logic [6:0]    cand, last;
    logic [CW-1:0] cnt;
    logic          accept;

    logic [4:0]    mem [DEPTH];
    logic [AW:0]   wptr, rptr;
    logic          empty, full, pop, push_ok;
    logic [4:0]    entry;

    // Returns {invalid, digit}; unknown patterns (blank included) decode to {1, 0}.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'h3F: decode = 5'h00;  7'h06: decode = 5'h01;
            7'h5B: decode = 5'h02;  7'h4F: decode = 5'h03;
            7'h66: decode = 5'h04;  7'h6D: decode = 5'h05;
            7'h7D: decode = 5'h06;  7'h07: decode = 5'h07;
            7'h7F: decode = 5'h08;  7'h6F: decode = 5'h09;
            7'h77: decode = 5'h0A;  7'h7C: decode = 5'h0B;
            7'h39: decode = 5'h0C;  7'h5E: decode = 5'h0D;
            7'h79: decode = 5'h0E;  7'h71: decode = 5'h0F;
            default: decode = 5'h10;
        endcase
    endfunction

    // Accept fires on the edge that brings cnt to STABLE_CYCLES, so a held pattern reports once.
    assign accept = ena && (seg_in == cand) && (cnt == CW'(STABLE_CYCLES - 1)) && (cand != last);
    assign entry  = decode(cand);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand <= '0;
            cnt  <= '0;
            last <= '0;
        end else if (ena) begin
            if (seg_in != cand) begin
                cand <= seg_in;
                cnt  <= CW'(1);
            end else if (cnt < CW'(STABLE_CYCLES)) begin
                cnt <= cnt + CW'(1);
            end
            if (accept) last <= cand;
        end
    end

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop     = !empty && bus.out_ready;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign push_ok = accept && (!full || pop);

    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr[AW-1:0]] <= entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop)     rptr <= rptr + 1'b1;
            if (accept && full && !pop) overflow <= 1'b1;
        end
    end

    assign bus.out_valid = !empty;
    assign {bus.out_invalid, bus.out_digit} = empty ? 5'd0 : mem[rptr[AW-1:0]];
endmodule

// File: tb/tb_seg7_capture.sv
// Directed self-checking bench for seg7_capture with default parameters.
module tb_seg7_capture;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [6:0] seg_in;
    logic       overflow;
    int         n_chk = 0;
    int         n_fail = 0;

    seg7_capture_if bus ();

    seg7_capture #(.STABLE_CYCLES(4), .DEPTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .seg_in   (seg_in),
        .overflow (overflow),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input logic [6:0] p, input int n);
        seg_in = p;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b0; seg_in = 7'h00; bus.out_ready = 1'b0;
        #3;
        n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", bus.out_valid); end
        n_chk++; if (bus.out_digit !== 4'h0) begin n_fail++; $display("FAIL reset_digit: got %0h want 0", bus.out_digit); end
        n_chk++; if (bus.out_invalid !== 1'b0) begin n_fail++; $display("FAIL reset_invalid: got %0b want 0", bus.out_invalid); end
        n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %0b want 0", overflow); end
        tick(); tick();
        rst_n = 1'b1; ena = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL blank_no_event cyc %0d: got %0b want 0", i, bus.out_valid); end
        end
        n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL blank_overflow: got %0b want 0", overflow); end
    endtask

    task automatic test_latency();
        seg_in = 7'h5B;
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL latency_early edge %0d: got %0b want 0", i, bus.out_valid); end
        end
        tick();
        n_chk++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL latency_valid: got %0b want 1", bus.out_valid); end
        n_chk++; if (bus.out_digit !== 4'h2) begin n_fail++; $display("FAIL latency_digit: got %0h want 2", bus.out_digit); end
        n_chk++; if (bus.out_invalid !== 1'b0) begin n_fail++; $display("FAIL latency_invalid: got %0b want 0", bus.out_invalid); end
        repeat (6) tick();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_single_event: got %0b want 0", bus.out_valid); end
    endtask

    task automatic test_glitch();
        for (int i = 0; i < 12; i++) begin
            seg_in = ((i / 2) % 2 == 0) ? 7'h06 : 7'h7F;
            tick();
            n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL glitch_suppressed cyc %0d: got %0b want 0", i, bus.out_valid); end
        end
        settle(7'h7F, 6);
        n_chk++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL glitch_settle_valid: got %0b want 1", bus.out_valid); end
        n_chk++; if (bus.out_digit !== 4'h8) begin n_fail++; $display("FAIL glitch_settle_digit: got %0h want 8", bus.out_digit); end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL glitch_one_event: got %0b want 0", bus.out_valid); end
    endtask

    task automatic test_overflow();
        settle(7'h3F, 6); settle(7'h06, 6); settle(7'h5B, 6); settle(7'h4F, 6); settle(7'h66, 6);
        n_chk++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_set: got %0b want 1", overflow); end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_chk++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL drain_valid %0d: got %0b want 1", i, bus.out_valid); end
            n_chk++; if (bus.out_digit !== 4'(i)) begin n_fail++; $display("FAIL drain_digit %0d: got %0h want %0h", i, bus.out_digit, i); end
            tick();
        end
        bus.out_ready = 1'b0;
        n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty (66 lost): got %0b want 0", bus.out_valid); end
        n_chk++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_sticky: got %0b want 1", overflow); end
    endtask

    task automatic test_full_pop();
        logic [3:0] exp_d [4];
        exp_d[0] = 4'h1; exp_d[1] = 4'h2; exp_d[2] = 4'h3; exp_d[3] = 4'hB;
        rst_n = 1'b0;
        #2;
        n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_clears_overflow: got %0b want 0", overflow); end
        rst_n = 1'b1;
        tick();
        settle(7'h3F, 6); settle(7'h06, 6); settle(7'h5B, 6); settle(7'h4F, 6);
        settle(7'h7C, 3);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_push_pop_overflow: got %0b want 0", overflow); end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_chk++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL full_pop_valid %0d: got %0b want 1", i, bus.out_valid); end
            n_chk++; if (bus.out_digit !== exp_d[i]) begin n_fail++; $display("FAIL full_pop_digit %0d: got %0h want %0h", i, bus.out_digit, exp_d[i]); end
            tick();
        end
        bus.out_ready = 1'b0;
        n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL full_pop_occupancy: got %0b want 0", bus.out_valid); end
        settle(7'h55, 6);
        n_chk++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL invalid_valid: got %0b want 1", bus.out_valid); end
        n_chk++; if (bus.out_invalid !== 1'b1) begin n_fail++; $display("FAIL invalid_flag: got %0b want 1", bus.out_invalid); end
        n_chk++; if (bus.out_digit !== 4'h0) begin n_fail++; $display("FAIL invalid_digit: got %0h want 0", bus.out_digit); end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        settle(7'h6D, 6); settle(7'h7D, 6);
        n_chk++; if (bus.out_digit !== 4'h5) begin n_fail++; $display("FAIL mid_head: got %0h want 5", bus.out_digit); end
        rst_n = 1'b0;
        #1;
        n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid: got %0b want 0", bus.out_valid); end
        n_chk++; if (bus.out_digit !== 4'h0) begin n_fail++; $display("FAIL mid_reset_digit: got %0h want 0", bus.out_digit); end
        tick();
        rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rearm_early edge %0d: got %0b want 0", i, bus.out_valid); end
        end
        tick();
        n_chk++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL rearm_valid: got %0b want 1", bus.out_valid); end
        n_chk++; if (bus.out_digit !== 4'h6) begin n_fail++; $display("FAIL rearm_digit: got %0h want 6", bus.out_digit); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
